// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - round-robin MCP320x-style SPI ADC scanner
// One frame per enabled channel: START, SGL/DIFF, address, wait bits, then DATA_W result bits.
module spi_adc_scanner #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 12,
    parameter int WAIT_BITS  = 2,
    parameter int SCLK_HALF  = 16,
    parameter int GAP_CYCLES = 512,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_reset,
    input  logic                     scan_en,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     diff_mode,
    output logic                     spi_clk,
    output logic                     spi_cs_n,
    output logic                     spi_mosi,
    input  logic                     spi_miso,
    output logic [DATA_W-1:0]        sample_data,
    output logic [CH_W-1:0]          sample_ch,
    output logic                     sample_valid,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     busy
);
    localparam int N_CLK = 2 + ADDR_W + WAIT_BITS + DATA_W;
    localparam int PH_W  = $clog2(2 * SCLK_HALF);
    localparam int BIT_W = $clog2(N_CLK);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(SCLK_HALF - 1);
    localparam logic [PH_W-1:0]  PH_END   = PH_W'(2 * SCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_CLK - 1);
    localparam logic [BIT_W-1:0] BIT_WAIT = BIT_W'(2 + ADDR_W);
    localparam logic [BIT_W-1:0] BIT_DATA = BIT_W'(2 + ADDR_W + WAIT_BITS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CMD, WAIT, DATA, GAP} state_t;

    state_t             state, state_next;
    logic [PH_W-1:0]    ph;
    logic [BIT_W-1:0]   bit_idx, bit_next;
    logic [GAP_W-1:0]   gap_cnt;
    logic [CH_W-1:0]    cur_ch, last_ch, sel_ch, lo_ch, hi_ch;
    logic               found_hi;
    logic [ADDR_W:0]    cmd_sr;
    logic [DATA_W-1:0]  rx;
    logic               bit_end, frame_end, start;

    // Next channel: lowest enabled index above last_ch, else lowest enabled overall.
    always_comb begin
        lo_ch    = '0;
        hi_ch    = '0;
        found_hi = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                lo_ch = CH_W'(i);
                if (i > int'(last_ch)) begin
                    hi_ch    = CH_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        sel_ch = found_hi ? hi_ch : lo_ch;
    end

    always_comb begin
        state_next = state;
        bit_end    = (ph == PH_END);
        frame_end  = bit_end && (bit_idx == BIT_LAST);
        bit_next   = bit_idx + 1'b1;
        case (state)
            IDLE: if (scan_en && |ch_mask) state_next = CMD;
            CMD, WAIT, DATA: begin
                if (frame_end)                state_next = GAP;
                else if (bit_end) begin
                    if (bit_next >= BIT_DATA)      state_next = DATA;
                    else if (bit_next >= BIT_WAIT) state_next = WAIT;
                    else                           state_next = CMD;
                end
            end
            GAP:  if (gap_cnt == GAP_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        start = (state == IDLE) && (state_next == CMD);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state        <= IDLE;
            spi_cs_n     <= 1'b1;
            spi_clk      <= 1'b0;
            spi_mosi     <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_ch    <= '0;
            ch_data      <= '0;
            last_ch      <= CH_W'(NUM_CH - 1);
            cur_ch       <= '0;
            cmd_sr       <= '0;
            rx           <= '0;
            ph           <= '0;
            bit_idx      <= '0;
            gap_cnt      <= '0;
        end else begin
            state        <= state_next;
            sample_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cur_ch   <= sel_ch;
                    last_ch  <= sel_ch;
                    cmd_sr   <= {~diff_mode, ADDR_W'(sel_ch)};
                    spi_cs_n <= 1'b0;
                    spi_clk  <= 1'b0;
                    spi_mosi <= 1'b1;
                    ph       <= '0;
                    bit_idx  <= '0;
                end
                CMD, WAIT, DATA: begin
                    ph <= ph + 1'b1;
                    if (ph == PH_MID) begin
                        spi_clk <= 1'b1;
                        if (state == DATA) rx <= {rx[DATA_W-2:0], spi_miso};
                    end
                    if (frame_end) begin
                        spi_cs_n     <= 1'b1;
                        spi_clk      <= 1'b0;
                        spi_mosi     <= 1'b0;
                        sample_data  <= rx;
                        sample_ch    <= cur_ch;
                        sample_valid <= 1'b1;
                        ch_data[cur_ch*DATA_W +: DATA_W] <= rx;
                        gap_cnt      <= '0;
                    end else if (bit_end) begin
                        // Command bits drain from cmd_sr; zeros follow through wait and data.
                        ph       <= '0;
                        bit_idx  <= bit_next;
                        spi_clk  <= 1'b0;
                        spi_mosi <= cmd_sr[ADDR_W];
                        cmd_sr   <= {cmd_sr[ADDR_W-1:0], 1'b0};
                    end
                end
                GAP: gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_adc_scanner.sv
// tb/tb_spi_adc_scanner.sv - scoreboard bench for spi_adc_scanner with an ADC pin model
module tb_spi_adc_scanner;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;

    logic sys_clk = 1'b0;
    logic sys_reset = 1'b1;
    logic scan_en = 1'b0;
    logic diff_mode = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic spi_clk, spi_cs_n, spi_mosi, spi_miso;
    logic [DATA_W-1:0] sample_data;
    logic [2:0] sample_ch;
    logic sample_valid, busy;
    logic [NUM_CH*DATA_W-1:0] ch_data;

    spi_adc_scanner #(
        .NUM_CH(NUM_CH), .ADDR_W(3), .DATA_W(DATA_W), .WAIT_BITS(2),
        .SCLK_HALF(4), .GAP_CYCLES(4)
    ) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .scan_en(scan_en),
        .ch_mask(ch_mask), .diff_mode(diff_mode), .spi_clk(spi_clk),
        .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .sample_data(sample_data), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .ch_data(ch_data), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC model: records MOSI on each rising SCLK, shifts its result out during bits 7..18.
    int rcnt = 0;
    logic [18:0] mosi_vec = '0;
    logic fixed_val = 1'b1;
    logic [11:0] adc_val;

    always @(negedge spi_cs_n) begin
        rcnt = 0;
        mosi_vec = '0;
    end

    always @(posedge spi_clk) begin
        if (!spi_cs_n) begin
            if (rcnt < 19) mosi_vec[18-rcnt] = spi_mosi;
            rcnt++;
        end
    end

    always_comb begin
        adc_val  = fixed_val ? 12'hA5C : (12'h100 + {9'b0, mosi_vec[16:14]});
        spi_miso = 1'b0;
        if (rcnt >= 7 && rcnt < 19) spi_miso = adc_val[11-(rcnt-7)];
    end

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
        logic        diff;
    } exp_t;
    exp_t q[$];
    exp_t e;

    task automatic push(input logic [2:0] ch, input logic [11:0] data, input logic diff);
        exp_t x;
        x.ch = ch; x.data = data; x.diff = diff;
        q.push_back(x);
    endtask

    logic cs_prev = 1'b1;
    logic v_prev = 1'b0;
    int cs_fall_cyc = 0;

    always @(negedge sys_clk) begin
        if (!sys_reset) begin
            if (cs_prev && !spi_cs_n) cs_fall_cyc = cyc;
            if (v_prev) chk("valid_pulse_width", sample_valid, 1'b0);
            if (sample_valid) begin
                chk("valid_expected", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sample_data", sample_data, e.data);
                    chk("sample_ch", sample_ch, e.ch);
                    chk("ch_data_slice", ch_data[e.ch*DATA_W +: DATA_W], e.data);
                    chk("latency", cyc - cs_fall_cyc, 152);
                    chk("sclk_rises", rcnt, 19);
                    chk("mosi_bits", mosi_vec, {1'b1, ~e.diff, e.ch, 14'b0});
                end
            end
        end
        cs_prev = spi_cs_n;
        v_prev  = sample_valid;
    end

    task automatic wait_valids(input int n, input int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            @(posedge sys_clk); #1;
            t++;
            if (sample_valid) got++;
        end
        chk("valid_wait", got, n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            @(posedge sys_clk); #1;
            t++;
        end
        chk("idle_wait", busy, 1'b0);
    endtask

    task automatic wait_cs_low(input int budget);
        int t = 0;
        while (spi_cs_n && t < budget) begin
            @(posedge sys_clk); #1;
            t++;
        end
        chk("cs_fall_wait", spi_cs_n, 1'b0);
    endtask

    task automatic quiet(input int n, input string name);
        int busy_hits = 0;
        int cs_low = 0;
        repeat (n) begin
            @(negedge sys_clk);
            if (busy) busy_hits++;
            if (!spi_cs_n) cs_low++;
        end
        chk({name, "_busy"}, busy_hits, 0);
        chk({name, "_cs"}, cs_low, 0);
    endtask

    initial begin
        int hi;
        repeat (3) @(posedge sys_clk);
        #1 sys_reset = 1'b0;
        @(negedge sys_clk);
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_spi_clk", spi_clk, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_sample_data", sample_data, 12'h0);
        chk("rst_sample_ch", sample_ch, 3'h0);
        chk("rst_ch_data", ch_data, 96'h0);

        ch_mask = 8'h01;
        quiet(200, "idle");

        // Single frame on channel 0 (last_ch starts at 7, wraps to 0).
        push(3'd0, 12'hA5C, 1'b0);
        scan_en = 1'b1;
        wait_valids(1, 400);
        scan_en = 1'b0;
        wait_idle(50);
        chk("ch_data_ch0", ch_data[11:0], 12'hA5C);

        // Round-robin 2,5,7,2 with back-to-back cs-high gap.
        fixed_val = 1'b0;
        ch_mask = 8'b1010_0100;
        push(3'd2, 12'h102, 1'b0);
        push(3'd5, 12'h105, 1'b0);
        push(3'd7, 12'h107, 1'b0);
        push(3'd2, 12'h102, 1'b0);
        scan_en = 1'b1;
        wait_valids(1, 400);
        hi = 0;
        while (spi_cs_n && hi < 100) begin
            hi++;
            @(posedge sys_clk); #1;
        end
        chk("cs_gap", hi, 5);
        wait_valids(3, 1000);
        scan_en = 1'b0;
        wait_idle(50);

        // Differential on channel 3.
        diff_mode = 1'b1;
        ch_mask = 8'h08;
        push(3'd3, 12'h103, 1'b1);
        scan_en = 1'b1;
        wait_valids(1, 400);
        scan_en = 1'b0;
        wait_idle(50);
        diff_mode = 1'b0;

        // scan_en dropped at bit 6: frame completes, nothing follows.
        push(3'd3, 12'h103, 1'b0);
        scan_en = 1'b1;
        wait_cs_low(50);
        repeat (6 * 8) @(posedge sys_clk);
        #1 scan_en = 1'b0;
        wait_valids(1, 400);
        wait_idle(50);
        quiet(300, "after_drop");

        // Reset at bit 10 aborts without a result.
        ch_mask = 8'h10;
        scan_en = 1'b1;
        wait_cs_low(50);
        repeat (10 * 8) @(posedge sys_clk);
        #1 sys_reset = 1'b1;
        scan_en = 1'b0;
        @(posedge sys_clk);
        #1 sys_reset = 1'b0;
        chk("abort_cs_n", spi_cs_n, 1'b1);
        chk("abort_ch_data", ch_data, 96'h0);
        chk("abort_sample_data", sample_data, 12'h0);
        chk("abort_busy", busy, 1'b0);
        quiet(200, "after_reset");

        // Mask change mid-frame only affects the following frame.
        ch_mask = 8'h02;
        push(3'd1, 12'h101, 1'b0);
        push(3'd6, 12'h106, 1'b0);
        scan_en = 1'b1;
        wait_cs_low(50);
        repeat (20) @(posedge sys_clk);
        #1 ch_mask = 8'h40;
        wait_valids(2, 1000);
        scan_en = 1'b0;
        wait_idle(50);

        // All channels masked: nothing starts until a channel is enabled.
        ch_mask = 8'h00;
        scan_en = 1'b1;
        quiet(300, "masked");
        ch_mask = 8'h80;
        push(3'd7, 12'h107, 1'b0);
        wait_valids(1, 400);
        scan_en = 1'b0;
        wait_idle(50);

        repeat (5) @(posedge sys_clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
